// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the operand-fetch stage, the execution unit and writeback.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, Negative, Carry, Overflow
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, Negative, Carry, Overflow
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked execution unit: single-cycle ALU ops, iterative one-bit-per-cycle shifts,
// result and flags held in HOLD until the consumer accepts them.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_unit_if.slave exe_io
);
    localparam int unsigned SUMW = WIDTH + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic [SHW-1:0]   amt;
    logic             is_shift;
    logic [WIDTH-1:0] shift_step;

    // Single-cycle datapath; slt reuses the subtractor and corrects the sign for overflow.
    always_comb begin
        is_sub    = (exe_io.ALUControl == OP_SUB) || (exe_io.ALUControl == OP_SLT);
        b_eff     = is_sub ? ~exe_io.SrcB : exe_io.SrcB;
        sum       = {1'b0, exe_io.SrcA} + {1'b0, b_eff} + SUMW'(is_sub);
        add_ovf   = (exe_io.SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != exe_io.SrcA[WIDTH-1]);
        amt       = exe_io.SrcB[SHW-1:0];
        is_shift  = (exe_io.ALUControl == OP_SLL) || (exe_io.ALUControl == OP_SRL);
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (exe_io.ALUControl)
            OP_ADD, OP_SUB: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = add_ovf;
            end
            OP_AND:  alu_res = exe_io.SrcA & exe_io.SrcB;
            OP_OR:   alu_res = exe_io.SrcA | exe_io.SrcB;
            OP_XOR:  alu_res = exe_io.SrcA ^ exe_io.SrcB;
            OP_SLT:  alu_res = WIDTH'(sum[WIDTH-1] ^ add_ovf);
            default: alu_res = exe_io.SrcA;
        endcase
    end

    // Next-state and result/flag capture.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        res_d      = res_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        shift_step = dir_q ? (work_q >> 1) : (work_q << 1);
        case (state_q)
            IDLE: begin
                if (exe_io.in_valid) begin
                    if (is_shift && (amt != '0)) begin
                        work_d  = exe_io.SrcA;
                        cnt_d   = amt;
                        dir_d   = (exe_io.ALUControl == OP_SRL);
                        state_d = SHIFT;
                    end else begin
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        neg_d   = alu_res[WIDTH-1];
                        carry_d = alu_carry;
                        ovf_d   = alu_ovf;
                        state_d = HOLD;
                    end
                end
            end
            SHIFT: begin
                work_d = shift_step;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    res_d   = shift_step;
                    zero_d  = (shift_step == '0);
                    neg_d   = shift_step[WIDTH-1];
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (exe_io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign exe_io.in_ready  = (state_q == IDLE) && rst_n;
    assign exe_io.out_valid = (state_q == HOLD);
    assign exe_io.ALUResult = res_q;
    assign exe_io.Zero      = zero_q;
    assign exe_io.Negative  = neg_q;
    assign exe_io.Carry     = carry_q;
    assign exe_io.Overflow  = ovf_q;
endmodule
